// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM encoding and the
// 3-sample majority helper. Intended to be reused by the transmitter.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        START       = 3'd1,
        DATA        = 3'd2,
        PARITY      = 3'd3,
        STOP        = 3'd4,
        ESPERA_ALTO = 3'd5
    } estado_t;

    function automatic logic mayoria3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_muestreo.sv
// rx synchroniser plus 3-sample majority voter around the bit centre.
// bitVal is meaningful on the tick where tickCnt = OVERSAMPLE/2 + 1.
module uart_rx_muestreo
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int TW         = $clog2(OVERSAMPLE)
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          rx,
    input  logic          tick,
    input  logic [TW-1:0] tickCnt,
    output logic          rxSync,
    output logic          bitVal
);

    localparam logic [TW-1:0] T_ANT = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_MED = TW'(OVERSAMPLE / 2);

    logic rxMeta;
    logic muestra0;
    logic muestra1;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rxMeta   <= 1'b1;
            rxSync   <= 1'b1;
            muestra0 <= 1'b1;
            muestra1 <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxSync <= rxMeta;
            if (tick && tickCnt == T_ANT) muestra0 <= rxSync;
            if (tick && tickCnt == T_MED) muestra1 <= rxSync;
        end
    end

    // Third sample is the live synchronised value at the resolution tick.
    assign bitVal = mayoria3(muestra0, muestra1, rxSync);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver, tick-gated; reports each frame to the command decoder.
// Optional UART_RX_BREAK_EN adds the pausa break strobe and the ESPERA_ALTO state.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dato,
    output logic                 hecho,
    output logic                 errParidad,
    output logic                 errTrama,
    output logic                 ocupado,
`ifdef UART_RX_BREAK_EN
    output logic                 pausa,
`endif
    output logic [2:0]           estadoDbg
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_RES    = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_FIN    = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    ULT_DATO = 4'(DATA_BITS - 1);
    localparam logic [3:0]    ULT_STOP = 4'(STOP_BITS - 1);

    // hecho and pausa are one-clk strobes with no back-pressure: the decoder
    // must take dato/errParidad/errTrama while hecho is high (they stay held anyway).

    estado_t              estado;
    logic [TW-1:0]        tickCnt;
    logic [3:0]           bitCnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 parBit;
    logic                 stopErr;
    logic                 stopUno;
    logic                 rxSync;
    logic                 bitVal;
    logic                 resol;
    logic                 finBit;
    logic                 errPar;
    logic                 esPausa;

    uart_rx_muestreo #(
        .OVERSAMPLE(OVERSAMPLE),
        .TW        (TW)
    ) u_muestreo (
        .clk    (clk),
        .rstN   (rstN),
        .rx     (rx),
        .tick   (tick),
        .tickCnt(tickCnt),
        .rxSync (rxSync),
        .bitVal (bitVal)
    );

    assign resol     = (tickCnt == T_RES);
    assign finBit    = (tickCnt == T_FIN);
    assign ocupado   = (estado != IDLE);
    assign estadoDbg = estado;

    always_comb begin
        errPar = 1'b0;
        if (PARITY_MODE == PARITY_EVEN) errPar = (^shreg) ^ parBit;
        else if (PARITY_MODE == PARITY_ODD) errPar = ~((^shreg) ^ parBit);
    end

`ifdef UART_RX_BREAK_EN
    // Break: every bit after the start resolved low, including the final stop sample.
    assign esPausa = (shreg == '0) && !((PARITY_MODE != PARITY_NONE) && parBit)
                     && !stopUno && !bitVal;
`else
    assign esPausa = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            estado     <= IDLE;
            tickCnt    <= '0;
            bitCnt     <= '0;
            shreg      <= '0;
            parBit     <= 1'b0;
            stopErr    <= 1'b0;
            stopUno    <= 1'b0;
            dato       <= '0;
            hecho      <= 1'b0;
            errParidad <= 1'b0;
            errTrama   <= 1'b0;
`ifdef UART_RX_BREAK_EN
            pausa      <= 1'b0;
`endif
        end else begin
            hecho <= 1'b0;
`ifdef UART_RX_BREAK_EN
            pausa <= 1'b0;
`endif
            if (tick) begin
                case (estado)
                    IDLE: begin
                        if (!rxSync) begin
                            estado  <= START;
                            tickCnt <= TW'(1);
                        end
                    end
                    START: begin
                        if (resol && bitVal) begin
                            estado  <= IDLE;
                            tickCnt <= '0;
                        end else if (finBit) begin
                            estado  <= DATA;
                            tickCnt <= '0;
                            bitCnt  <= '0;
                        end else begin
                            tickCnt <= tickCnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (resol) shreg <= {bitVal, shreg[DATA_BITS-1:1]};
                        if (finBit) begin
                            tickCnt <= '0;
                            if (bitCnt == ULT_DATO) begin
                                bitCnt  <= '0;
                                stopErr <= 1'b0;
                                stopUno <= 1'b0;
                                estado  <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                            end else begin
                                bitCnt <= bitCnt + 1'b1;
                            end
                        end else begin
                            tickCnt <= tickCnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (resol) parBit <= bitVal;
                        if (finBit) begin
                            tickCnt <= '0;
                            estado  <= STOP;
                        end else begin
                            tickCnt <= tickCnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (resol && bitCnt == ULT_STOP) begin
                            // Leave at the bit centre so the next start edge is not missed.
                            estado  <= IDLE;
                            tickCnt <= '0;
                            bitCnt  <= '0;
                            if (esPausa) begin
`ifdef UART_RX_BREAK_EN
                                pausa  <= 1'b1;
                                estado <= ESPERA_ALTO;
`endif
                            end else begin
                                hecho      <= 1'b1;
                                dato       <= shreg;
                                errParidad <= errPar;
                                errTrama   <= stopErr | ~bitVal;
                            end
                        end else begin
                            if (resol) begin
                                if (bitVal) stopUno <= 1'b1;
                                else stopErr <= 1'b1;
                            end
                            if (finBit) begin
                                tickCnt <= '0;
                                bitCnt  <= bitCnt + 1'b1;
                            end else begin
                                tickCnt <= tickCnt + 1'b1;
                            end
                        end
                    end
                    ESPERA_ALTO: begin
                        if (rxSync) estado <= IDLE;
                    end
                    default: begin
                        estado  <= IDLE;
                        tickCnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised, oversampling UART receiver. Replaces the baud-clocked receiver.
- Runs on the system clock and is gated by a one-cycle `tick` enable from the baud generator at OVERSAMPLE × baud.
- Configurable data width, parity mode and stop bits; 3-sample majority vote per bit.
- Reports data, parity error and framing error together with a one-cycle `hecho` strobe to the command decoder.

Parameters:
- DATA_BITS, 8: data bits per frame, legal 5..9, sent LSB first.
- PARITY_MODE, 1: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- OVERSAMPLE, 16: ticks per bit, legal 8..32, even.

Ports:
- clk  in  1  system clock.
- rstN  in  1  asynchronous active-low reset.
- tick  in  1  oversample enable; one clk wide, OVERSAMPLE per bit.
- rx  in  1  asynchronous serial input, idle high.
- dato  out  DATA_BITS  last received data word.
- hecho  out  1  one-cycle pulse; frame complete.
- errParidad  out  1  parity error of last frame.
- errTrama  out  1  framing error (a stop bit sampled low) of last frame.
- ocupado  out  1  high while state ≠ IDLE.

Behaviour:
- Reset values:
  - rx 2-flop synchroniser resets to 1.
  - dato = 0, hecho = 0, errParidad = 0, errTrama = 0, ocupado = 0.
  - state = IDLE, counters = 0.
- rstN assertion mid-frame aborts the frame immediately; no hecho is produced.
- All counting and state changes occur only on clk edges with tick = 1; hecho is the only output that changes on a non-tick cycle (its deassertion).
- Sampling:
  - tickCnt runs 0..OVERSAMPLE-1 within each bit.
  - Samples are taken at M-1, M and M+1, where M = OVERSAMPLE/2.
  - The bit value is the majority of the 3 samples, resolved at tickCnt = M+1.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tick with rxSync = 0 → START, tickCnt = 1.
  - START: if the start-bit majority is 1 → IDLE (false start: no hecho, outputs unchanged). Otherwise at tickCnt = OVERSAMPLE-1 → DATA, tickCnt = 0, bitCnt = 0.
  - DATA: the majority is shifted into a shift register LSB first. After DATA_BITS bits → PARITY if PARITY_MODE ≠ 0, else → STOP.
  - PARITY: the sampled bit p is captured.
    - Error when (XOR of data) ^ p ≠ 0 for even parity, and when it ≠ 1 for odd parity.
    - PARITY_MODE = 0 forces errParidad to 0.
  - STOP: each stop bit is sampled. Any stop sample of 0 sets the frame's framing flag.
    - At the resolution point (tickCnt = M+1) of the last stop bit, state → IDLE without waiting for the end of the bit, so the receiver can resync on the next start edge.
- Output update: in the clk cycle after the last-stop resolution tick:
  - hecho = 1 for exactly one clk.
  - dato, errParidad and errTrama are loaded simultaneously and held until the next completed frame.
- A low stop bit (without UART_RX_BREAK_EN): errTrama = 1, return to IDLE. A line that is still low re-triggers START on the next tick.
- The tick rate is the integrator's responsibility. With tick held 0 the block is frozen, except that a pending hecho still deasserts.

Optional Feature:
UART_RX_BREAK_EN
- Defined: adds output port `pausa` (1 bit, reset 0).
  - A frame whose data bits, parity bit and stop bits all resolve to 0 is a break.
  - On a break: pausa pulses for one clk in place of hecho; dato and the error flags are unchanged.
  - The FSM then enters an extra state ESPERA_ALTO and stays there until rxSync = 1 on a tick, then → IDLE.
- Undefined: there is no pausa port; a break is reported as a normal frame with dato = 0 and errTrama = 1.

Decomposition:
- Package uart_pkg:
  - PARITY_NONE/EVEN/ODD constants.
  - FSM state encoding (including ESPERA_ALTO).
  - Shared with the future transmitter.
- Sub-module uart_rx_muestreo: 2-flop synchroniser plus the 3-sample majority voter.
  - Inputs: clk, rstN, rx, tick, tickCnt.
  - Outputs: rxSync, bitVal.

Test Plan:
All scenarios use defaults (8 data bits, even parity, 1 stop, OVERSAMPLE = 16) with tick every 4 clk.
1. Send 0x35 ('5', 4 ones) with parity 0 → one hecho pulse, dato = 0x35, errParidad = 0, errTrama = 0, ocupado low afterwards.
2. Send 0x31 ('1', 3 ones) with parity bit 0 → hecho, dato = 0x31, errParidad = 1.
3. Drive rx low for 3 ticks only → ocupado rises then falls, no hecho, dato unchanged.
4. Send 0x4A with the stop bit low → hecho, dato = 0x4A, errTrama = 1. Then a valid 0x30 → errTrama = 0.
5. Apply a 1-tick low glitch at tickCnt = M inside data bit 3 of 0xFF → dato = 0xFF (majority rejects it). Apply rstN low at data bit 5 of the next frame → all outputs 0, no hecho.
6. With UART_RX_BREAK_EN defined: hold rx low for 12 bit times → one pausa pulse, no hecho. Raise rx, then send 0x39 → hecho with dato = 0x39.
